data_mem_port_ctrl: RTL and testbench

RAM-side port controller placed between the AXI-to-SRAM bridge and the single-port data RAM macro wrapper. After reset it zero-fills the whole RAM with an initialisation sweep. It then arbitrates the RAM between two ports:

- **Port A**: the bridge. It has no grant signal, so it always has priority.
- **Port B**: a loader/debug port with a req/gnt handshake and a registered read-valid.

The SoC holds the core in reset until `init_done_o` rises.

---
 rtl/data_mem_port_ctrl_if.sv | 55 +++++
 rtl/data_mem_port_ctrl.sv | 137 +++++++++++++
 tb/tb_data_mem_port_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_port_ctrl_if.sv
// Bus bundle between the data RAM port controller and its surroundings:
// port A (bridge, no grant), port B (loader/debug, req/gnt), and the RAM
// macro wrapper signals. The master modport is the environment side
// (bridge, loader and RAM); the slave modport is the controller.
interface data_mem_port_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // Port A: bridge side, always has priority
  logic                  a_req_i;
  logic                  a_we_i;
  logic [ADDR_WIDTH-1:0] a_addr_i;
  logic [BE_WIDTH-1:0]   a_be_i;
  logic [DATA_WIDTH-1:0] a_wdata_i;
  logic [DATA_WIDTH-1:0] a_rdata_o;
  logic                  a_drop_o;

  // Port B: loader/debug side with req/gnt handshake
  logic                  b_req_i;
  logic                  b_we_i;
  logic [ADDR_WIDTH-1:0] b_addr_i;
  logic [BE_WIDTH-1:0]   b_be_i;
  logic [DATA_WIDTH-1:0] b_wdata_i;
  logic                  b_gnt_o;
  logic                  b_rvalid_o;
  logic [DATA_WIDTH-1:0] b_rdata_o;

  // RAM macro wrapper side
  logic                  ram_en_o;
  logic                  ram_we_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [BE_WIDTH-1:0]   ram_be_o;
  logic [DATA_WIDTH-1:0] ram_wdata_o;
  logic [DATA_WIDTH-1:0] ram_rdata_i;

  modport master (
    output a_req_i, a_we_i, a_addr_i, a_be_i, a_wdata_i,
    input  a_rdata_o, a_drop_o,
    output b_req_i, b_we_i, b_addr_i, b_be_i, b_wdata_i,
    input  b_gnt_o, b_rvalid_o, b_rdata_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o,
    output ram_rdata_i
  );

  modport slave (
    input  a_req_i, a_we_i, a_addr_i, a_be_i, a_wdata_i,
    output a_rdata_o, a_drop_o,
    input  b_req_i, b_we_i, b_addr_i, b_be_i, b_wdata_i,
    output b_gnt_o, b_rvalid_o, b_rdata_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o,
    input  ram_rdata_i
  );
endinterface

// File: rtl/data_mem_port_ctrl.sv
// RAM-side port controller for the single-port data RAM.
// Port A (bridge) always wins; port B (loader/debug) gets the RAM only when
// port A is idle and sees a registered read-valid one cycle after its grant.
// Optional feature macro: DATA_MEM_ZERO_INIT_EN. When defined, the block
// starts in an INIT sweep that writes INIT_PATTERN to every word before
// normal arbitration begins; when undefined, it comes out of reset in RUN.
module data_mem_port_ctrl #(
  parameter int                    RAM_SIZE     = 65536,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = $clog2(RAM_SIZE),
  parameter logic [DATA_WIDTH-1:0] INIT_PATTERN = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_mem_port_ctrl_if.slave   bus,
  output logic                  init_done_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  w_init;
  logic [ADDR_WIDTH-1:0] w_init_addr;
  logic                  w_b_gnt;
  logic                  r_b_rvalid;

`ifdef DATA_MEM_ZERO_INIT_EN
  localparam int NWORDS = RAM_SIZE / BE_WIDTH;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int OFF_W  = $clog2(BE_WIDTH);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_a_drop;

  // State and sweep counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Sweep advance: one word per cycle, leave INIT after the last word
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == S_INIT) begin
      if (r_cnt == CNT_W'(NWORDS - 1)) begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // A port A request seen during the sweep is reported one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_drop <= 1'b0;
    end else begin
      r_a_drop <= (r_state == S_INIT) && bus.a_req_i;
    end
  end

  assign w_init       = (r_state == S_INIT);
  assign w_init_addr  = ADDR_WIDTH'(r_cnt) << OFF_W;
  assign bus.a_drop_o = r_a_drop;
  // The state register is the done flag: it reads RUN from the cycle after
  // the last sweep write.
  assign init_done_o  = (r_state == S_RUN);
`else
  assign w_init       = 1'b0;
  assign w_init_addr  = '0;
  assign bus.a_drop_o = 1'b0;
  assign init_done_o  = 1'b1;
`endif

  // RAM mux: sweep, then port A, then port B, otherwise idle with zeros
  always_comb begin
    // NOTE: every output gets a default before the priority chain so no
    // path leaves a signal unassigned and no latch is inferred.
    bus.ram_en_o    = 1'b0;
    bus.ram_we_o    = 1'b0;
    bus.ram_addr_o  = '0;
    bus.ram_be_o    = '0;
    bus.ram_wdata_o = '0;
    w_b_gnt         = 1'b0;
    if (w_init) begin
      bus.ram_en_o    = 1'b1;
      bus.ram_we_o    = 1'b1;
      bus.ram_addr_o  = w_init_addr;
      bus.ram_be_o    = '1;
      bus.ram_wdata_o = INIT_PATTERN;
    end else if (bus.a_req_i) begin
      bus.ram_en_o    = 1'b1;
      bus.ram_we_o    = bus.a_we_i;
      bus.ram_addr_o  = bus.a_addr_i;
      bus.ram_be_o    = bus.a_be_i;
      bus.ram_wdata_o = bus.a_wdata_i;
    end else if (bus.b_req_i) begin
      w_b_gnt         = 1'b1;
      bus.ram_en_o    = 1'b1;
      bus.ram_we_o    = bus.b_we_i;
      bus.ram_addr_o  = bus.b_addr_i;
      bus.ram_be_o    = bus.b_be_i;
      bus.ram_wdata_o = bus.b_wdata_i;
    end
  end

  // Port B read-valid lines up with the RAM's one-cycle read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_rvalid <= 1'b0;
    end else begin
      r_b_rvalid <= w_b_gnt && !bus.b_we_i;
    end
  end

  assign bus.b_gnt_o    = w_b_gnt;
  assign bus.b_rvalid_o = r_b_rvalid;
  assign bus.a_rdata_o  = bus.ram_rdata_i;
  assign bus.b_rdata_o  = bus.ram_rdata_i;

endmodule

// File: tb/tb_data_mem_port_ctrl.sv
// Testbench for data_mem_port_ctrl on a 64-byte, 32-bit RAM.
// Stimulus drives both ports and keeps a word-array reference of RAM
// contents; expected read data is queued at issue time and a monitor pops
// and compares whenever a read result is presented.
module tb_data_mem_port_ctrl;

  localparam int RAM_SIZE = 64;
  localparam int DW       = 32;
  localparam int AW       = 6;
  localparam int NW       = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic init_done;

  data_mem_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  data_mem_port_ctrl #(
    .RAM_SIZE     (RAM_SIZE),
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .INIT_PATTERN (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .init_done_o (init_done)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency
  logic [DW-1:0] ram_mem [NW];
  logic [DW-1:0] ram_q;
  initial for (int i = 0; i < NW; i++) ram_mem[i] = 32'hA5A5_0000 | i;
  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      if (bus.ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_be_o[b]) ram_mem[bus.ram_addr_o[5:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
      end else begin
        ram_q <= ram_mem[bus.ram_addr_o[5:2]];
      end
    end
  end
  assign bus.ram_rdata_i = ram_q;

  // Reference model state and scoreboards
  logic [DW-1:0] ref_mem [NW];
  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];
  bit            exp_run = 1'b0;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_write(input logic [5:0] addr, input logic [3:0] be, input logic [31:0] wd);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[addr[5:2]][8*b +: 8] = wd[8*b +: 8];
  endfunction

  // Monitor: port A data is due the cycle after a RUN read; port B on rvalid
  bit a_rd_prev = 1'b0;
  always @(posedge clk) a_rd_prev <= rst_n && exp_run && bus.a_req_i && !bus.a_we_i;

  always @(negedge clk) begin
    if (a_rd_prev) begin
      if (exp_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_rdata: read result with no expected entry at %0t", $time);
      end else begin
        check("a_rdata", bus.a_rdata_o, exp_a.pop_front());
      end
    end
    if (bus.b_rvalid_o) begin
      if (exp_b.size() == 0) check("b_rvalid_unexpected", bus.b_rvalid_o, 1'b0);
      else                   check("b_rdata", bus.b_rdata_o, exp_b.pop_front());
    end
  end

  task automatic idle_inputs();
    bus.a_req_i = 0; bus.a_we_i = 0; bus.a_addr_i = '0; bus.a_be_i = '0; bus.a_wdata_i = '0;
    bus.b_req_i = 0; bus.b_we_i = 0; bus.b_addr_i = '0; bus.b_be_i = '0; bus.b_wdata_i = '0;
  endtask

  // One RUN-state cycle: drive, update the model, check arbitration mid-cycle
  task automatic do_cycle(
    input logic a_req, input logic a_we, input logic [5:0] a_addr, input logic [3:0] a_be, input logic [31:0] a_wd,
    input logic b_req, input logic b_we, input logic [5:0] b_addr, input logic [3:0] b_be, input logic [31:0] b_wd,
    output bit granted);
    bus.a_req_i = a_req; bus.a_we_i = a_we; bus.a_addr_i = a_addr; bus.a_be_i = a_be; bus.a_wdata_i = a_wd;
    bus.b_req_i = b_req; bus.b_we_i = b_we; bus.b_addr_i = b_addr; bus.b_be_i = b_be; bus.b_wdata_i = b_wd;
    granted = b_req && !a_req;
    if (a_req) begin
      if (a_we) ref_write(a_addr, a_be, a_wd);
      else      exp_a.push_back(ref_mem[a_addr[5:2]]);
    end else if (b_req) begin
      if (b_we) ref_write(b_addr, b_be, b_wd);
      else      exp_b.push_back(ref_mem[b_addr[5:2]]);
    end
    @(negedge clk);
    check("b_gnt", bus.b_gnt_o, granted);
    check("ram_en", bus.ram_en_o, a_req || b_req);
    check("a_drop_run", bus.a_drop_o, 1'b0);
    check("init_done_run", init_done, 1'b1);
    if (a_req) begin
      check("ram_addr_a", bus.ram_addr_o, a_addr);
      check("ram_we_a", bus.ram_we_o, a_we);
      check("ram_be_a", bus.ram_be_o, a_be);
      check("ram_wdata_a", bus.ram_wdata_o, a_wd);
    end else if (b_req) begin
      check("ram_addr_b", bus.ram_addr_o, b_addr);
      check("ram_we_b", bus.ram_we_o, b_we);
      check("ram_be_b", bus.ram_be_o, b_be);
      check("ram_wdata_b", bus.ram_wdata_o, b_wd);
    end else begin
      check("ram_we_idle", bus.ram_we_o, 1'b0);
      check("ram_addr_idle", bus.ram_addr_o, 6'd0);
    end
    @(posedge clk); #1;
  endtask

`ifdef DATA_MEM_ZERO_INIT_EN
  // Sweep check from the cycle of the first write; optionally abort at a
  // given word (returns just after that cycle's edge) and pulse port A at 5.
  task automatic run_sweep(input int abort_at, input bit do_drop);
    for (int i = 0; i < NW; i++) begin
      if (i == abort_at) return;
      bus.a_req_i = do_drop && (i == 5);
      bus.b_req_i = do_drop && (i == 5);
      bus.a_addr_i = 6'h2C;
      @(negedge clk);
      check("sweep_en", bus.ram_en_o, 1'b1);
      check("sweep_we", bus.ram_we_o, 1'b1);
      check("sweep_addr", bus.ram_addr_o, i * 4);
      check("sweep_be", bus.ram_be_o, 4'hF);
      check("sweep_wdata", bus.ram_wdata_o, 32'h0);
      check("sweep_gnt", bus.b_gnt_o, 1'b0);
      check("sweep_done", init_done, 1'b0);
      check("sweep_drop", bus.a_drop_o, do_drop && (i == 6));
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    check("init_done_rise", init_done, 1'b1);
    check("post_sweep_en", bus.ram_en_o, 1'b0);
    check("post_sweep_drop", bus.a_drop_o, 1'b0);
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    bit b_pend;
    logic b_req, b_we;
    logic [5:0] b_addr;
    logic [3:0] b_be;
    logic [31:0] b_wd;

    for (int i = 0; i < NW; i++) ref_mem[i] = 32'hA5A5_0000 | i;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_a_drop", bus.a_drop_o, 1'b0);
    check("rst_b_rvalid", bus.b_rvalid_o, 1'b0);
    check("rst_b_gnt", bus.b_gnt_o, 1'b0);

`ifdef DATA_MEM_ZERO_INIT_EN
    check("rst_init_done", init_done, 1'b0);
    check("rst_ram_en", bus.ram_en_o, 1'b1);
    check("rst_ram_addr", bus.ram_addr_o, 6'd0);
    check("rst_ram_we", bus.ram_we_o, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_sweep(9, 1'b1);
    // Reset during the sweep: it must restart from word 0
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("midrst_init_done", init_done, 1'b0);
    check("midrst_ram_addr", bus.ram_addr_o, 6'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_sweep(-1, 1'b0);
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
    exp_run = 1'b1;
`else
    check("rst_init_done", init_done, 1'b1);
    check("rst_ram_en", bus.ram_en_o, 1'b0);
    exp_run = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Port A is serviced in the very first cycle after release
    do_cycle(1, 0, 6'h0C, 4'hF, 32'h0, 0, 0, 6'h0, 4'h0, 32'h0, g);
    for (int i = 0; i < NW; i++)
      do_cycle(1, 1, 6'(i * 4), 4'hF, 32'h0, 0, 0, 6'h0, 4'h0, 32'h0, g);
`endif

    // Priority: A write and B read collide; B wins the following cycle
    do_cycle(1, 1, 6'h10, 4'hF, 32'hDEAD_BEEF, 1, 0, 6'h10, 4'hF, 32'h0, g);
    do_cycle(0, 0, 6'h00, 4'h0, 32'h0,         1, 0, 6'h10, 4'hF, 32'h0, g);
    do_cycle(0, 0, 6'h00, 4'h0, 32'h0,         0, 0, 6'h00, 4'h0, 32'h0, g);
    // Byte enables: B partial write then A read back
    do_cycle(0, 0, 6'h00, 4'h0, 32'h0,         1, 1, 6'h08, 4'b0101, 32'h1122_3344, g);
    do_cycle(1, 0, 6'h08, 4'hF, 32'h0,         0, 0, 6'h00, 4'h0, 32'h0, g);
    do_cycle(0, 0, 6'h00, 4'h0, 32'h0,         0, 0, 6'h00, 4'h0, 32'h0, g);

    // Randomized traffic; a denied B request is held unchanged
    b_pend = 1'b0;
    b_req = 0; b_we = 0; b_addr = '0; b_be = '0; b_wd = '0;
    for (int n = 0; n < 400; n++) begin
      logic a_req, a_we;
      logic [5:0] a_addr;
      logic [3:0] a_be;
      logic [31:0] a_wd;
      a_req  = ($urandom_range(0, 99) < 40);
      a_we   = 1'($urandom_range(0, 1));
      a_addr = {4'($urandom_range(0, 15)), 2'b00};
      a_be   = 4'($urandom_range(0, 15));
      a_wd   = $urandom;
      if (!b_pend) begin
        b_req  = 1'($urandom_range(0, 1));
        b_we   = 1'($urandom_range(0, 1));
        b_addr = {4'($urandom_range(0, 15)), 2'b00};
        b_be   = 4'($urandom_range(0, 15));
        b_wd   = $urandom;
      end
      do_cycle(a_req, a_we, a_addr, a_be, a_wd, b_req, b_we, b_addr, b_be, b_wd, g);
      b_pend = b_req && !g;
    end

    // Drain: finish any held B request, then let read results come back
    while (b_pend) begin
      do_cycle(0, 0, 6'h0, 4'h0, 32'h0, b_req, b_we, b_addr, b_be, b_wd, g);
      b_pend = b_req && !g;
    end
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("a_queue_empty", exp_a.size(), 0);
    check("b_queue_empty", exp_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
